pixel_fifo_rd_ctrl: RTL and testbench
=====================================

Name: pixel_fifo_rd_ctrl

Overview:
- Read-side sequencer for the pixel FIFO in the system clock domain (i_sys_clk).
- Issues rd_en to the FIFO, absorbs the FIFO's 1-cycle read latency with a 2-entry skid buffer, and delivers a valid/ready pixel stream to the conv front end.
- Counts frame geometry and tags each pixel with row, column, start-of-frame, end-of-line and end-of-frame, so downstream line buffers never count pixels themselves.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 28, pixels per line.
- IMG_H, 28, lines per frame.

Ports:
- i_sys_clk  in  1  system clock; the only clock.
- i_rst  in  1  synchronous, active-low reset (asserted when 0).
- i_start  in  1  one-cycle pulse that arms one frame; ignored unless in IDLE.
- i_fifo_valid  in  1  FIFO not empty.
- i_fifo_data  in  DATA_W  FIFO dout, valid the cycle after an accepted rd_en.
- o_fifo_rd_en  out  1  FIFO read strobe.
- o_pixel  out  DATA_W  pixel to downstream.
- o_pixel_valid  out  1  o_pixel and tags valid.
- i_pixel_ready  in  1  downstream accepts this cycle.
- o_row  out  $clog2(IMG_H)  row index of o_pixel.
- o_col  out  $clog2(IMG_W)  column index of o_pixel.
- o_sof  out  1  o_pixel is (0,0).
- o_eol  out  1  o_col == IMG_W-1.
- o_eof  out  1  last pixel of frame.
- o_busy  out  1  state != IDLE.
- o_frame_done  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - state=IDLE; all outputs 0.
  - Skid buffer emptied; in-flight flag, issue counter and row/col counters cleared.
  - Reset mid-frame abandons the frame; any FIFO word already read is discarded.
- States:
  - IDLE: go to STREAM on i_start.
  - STREAM: issue reads. When issue count reaches IMG_W*IMG_H, go to DRAIN.
  - DRAIN: no reads. After the last output handshake, go to IDLE and pulse o_frame_done for 1 cycle, registered in the cycle after that handshake.
- Read issue:
  - o_fifo_rd_en = (state==STREAM) && i_fifo_valid && (issued < IMG_W*IMG_H) && (skid_cnt + inflight − pop < 2).
  - pop = o_pixel_valid && i_pixel_ready.
  - o_fifo_rd_en is combinational from registered state and i_fifo_valid.
- Read capture:
  - inflight <= o_fifo_rd_en.
  - When inflight==1, i_fifo_data is written to the skid buffer that cycle.
  - The skid buffer never overflows under the issue rule.
- Throughput:
  - Sustained 1 pixel/cycle when the FIFO is non-empty and ready is held high.
  - Latency from first rd_en to first o_pixel_valid is 2 cycles: data is registered into the skid head.
- Output:
  - o_pixel and o_pixel_valid come from the skid head.
  - Once o_pixel_valid is high, o_pixel and the tags hold stable until pop (AXI-style).
- Coordinates:
  - col increments on pop and wraps at IMG_W-1 to 0, where row increments.
  - After the last pixel, row and col wrap to 0.
  - Tags are combinational from the counters.
- Boundaries:
  - FIFO empty mid-line: rd_en drops; o_pixel_valid drops after the skid drains. Counters hold.
  - Simultaneous capture and pop with skid_cnt==2 cannot occur; the issue rule prevents it.
  - i_start while busy: ignored.
  - i_pixel_ready low for any length of time: no data is lost and no extra reads are issued.

Decomposition:
- Package pixel_ctrl_pkg: state enum (IDLE, STREAM, DRAIN), frame-size constant IMG_W*IMG_H, and the row/column width localparams.
- One sub-module: pixel_skid_buf, a 2-entry valid/ready skid buffer parameterised by DATA_W. It carries its count output for the issue rule.

Test Plan:
- Reset/idle: hold i_rst=0 for 3 cycles, then release with no i_start → all outputs 0 and o_fifo_rd_en never asserts even with i_fifo_valid=1.
- Full-rate frame: IMG_W=IMG_H=4, FIFO model pre-loaded with bytes 0..15, ready=1, pulse i_start → 16 pixels in order 0..15 on consecutive cycles.
  - Tags: o_sof on pixel 0; o_eol on cols 3/7/11/15; o_eof on pixel 15.
  - o_frame_done exactly 1 cycle after the last handshake; exactly 16 rd_en total.
- Backpressure: ready toggling with pattern 1,0,0,1 → o_pixel stable while ready=0, no lost or duplicated data, skid count ≤2, rd_en count still 16.
- Starved FIFO: i_fifo_valid low for 5 cycles after pixel 6 → o_pixel_valid gaps, and pixel 7 arrives with o_row=1, o_col=3.
- Mid-frame reset: assert i_rst=0 after 9 pops, then restart with a new i_start → the new frame begins at row 0, col 0 with o_sof=1, and o_busy was 0 during reset.
- Start while busy: i_start pulses during STREAM → ignored; exactly one o_frame_done, and total reads are 16.

Source files
------------

// File: rtl/pixel_fifo_rd_ctrl_pkg.sv
// Shared types and geometry helpers for the pixel FIFO read-side sequencer.
package pixel_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_IMG_W  = 28;
  localparam int unsigned DEF_IMG_H  = 28;

  function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  // Index width for a 0..n-1 counter; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_fifo_rd_ctrl_if.sv
// FIFO read port plus tagged pixel stream between the sequencer and its neighbours.
interface pixel_fifo_rd_ctrl_if
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H
);
  localparam int unsigned ROW_W = idx_w(IMG_H);
  localparam int unsigned COL_W = idx_w(IMG_W);

  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] pixel;
  logic              pixel_valid;
  logic              pixel_ready;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              sof;
  logic              eol;
  logic              eof;

  modport master (
    input  fifo_valid, fifo_data, pixel_ready,
    output fifo_rd_en, pixel, pixel_valid, row, col, sof, eol, eof
  );

  modport slave (
    output fifo_valid, fifo_data, pixel_ready,
    input  fifo_rd_en, pixel, pixel_valid, row, col, sof, eol, eof
  );

endinterface

// File: rtl/pixel_fifo_rd_ctrl_skid_buf.sv
// Two-entry skid buffer that absorbs the FIFO's one-cycle read latency.
module pixel_skid_buf #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              i_sys_clk,
  input  logic              i_rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] tail;
  logic              do_pop;

  assign do_pop = rd_en && (count != 2'd0);
  assign data   = head;
  assign valid  = (count != 2'd0);

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({wr_en, do_pop})
        2'b10: begin
          if (count == 2'd0) begin
            head  <= wr_data;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            tail  <= wr_data;
            count <= 2'd2;
          end
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= wr_data;
          end else begin
            head <= tail;
            tail <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pixel_fifo_rd_ctrl.sv
// Pixel FIFO read sequencer: issues reads, buffers the returned words and tags
// each delivered pixel with its frame coordinates.
module pixel_fifo_rd_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H
) (
  input  logic                  i_sys_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  pixel_fifo_rd_ctrl_if.master  bus,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int unsigned FRAME = frame_pixels(IMG_W, IMG_H);
  localparam int unsigned ROW_W = idx_w(IMG_H);
  localparam int unsigned COL_W = idx_w(IMG_W);
  localparam int unsigned ISS_W = $clog2(FRAME + 1);

  localparam logic [ISS_W-1:0] FRAME_CNT = ISS_W'(FRAME);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_W - 1);

  state_t           state;
  state_t           state_nxt;
  logic [ISS_W-1:0] issued;
  logic             inflight;
  logic             rd_en;
  logic             pop;
  logic             room;
  logic             last_px;
  logic [2:0]       occ;
  logic [1:0]       skid_cnt;
  logic             skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  pixel_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .i_sys_clk (i_sys_clk),
    .i_rst     (i_rst),
    .wr_en     (inflight),
    .wr_data   (bus.fifo_data),
    .rd_en     (bus.pixel_ready),
    .data      (skid_data),
    .valid     (skid_valid),
    .count     (skid_cnt)
  );

  assign pop     = skid_valid && bus.pixel_ready;
  assign last_px = (row == LAST_ROW) && (col == LAST_COL);

  // skid + inflight - pop < 2, rearranged so the arithmetic cannot underflow.
  assign occ  = {1'b0, skid_cnt} + {2'b00, inflight};
  assign room = occ < (3'd2 + {2'b00, pop});

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE:   if (i_start) state_nxt = STREAM;
      STREAM: begin
        if (issued == FRAME_CNT) state_nxt = DRAIN;
        rd_en = bus.fifo_valid && (issued < FRAME_CNT) && room;
      end
      DRAIN:  if (pop && last_px) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst) begin
      state        <= IDLE;
      issued       <= '0;
      inflight     <= 1'b0;
      row          <= '0;
      col          <= '0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      inflight     <= rd_en;
      o_frame_done <= (state == DRAIN) && pop && last_px;
      if ((state == IDLE) && i_start) begin
        issued <= '0;
      end else if (rd_en) begin
        issued <= issued + 1'b1;
      end
      if (pop) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign bus.fifo_rd_en  = rd_en;
  assign bus.pixel       = skid_data;
  assign bus.pixel_valid = skid_valid;
  assign bus.row         = row;
  assign bus.col         = col;
  assign bus.sof         = skid_valid && (row == '0) && (col == '0);
  assign bus.eol         = skid_valid && (col == LAST_COL);
  assign bus.eof         = skid_valid && last_px;
  assign o_busy          = (state != IDLE);

endmodule

// File: tb/tb_pixel_fifo_rd_ctrl.sv
// Directed bench for pixel_fifo_rd_ctrl on a 4x4 frame with a behavioural FIFO.
module tb_pixel_fifo_rd_ctrl;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic i_rst = 1'b0;
  logic i_start = 1'b0;
  logic o_busy;
  logic o_frame_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pixel_fifo_rd_ctrl_if #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) bus ();

  pixel_fifo_rd_ctrl #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .i_sys_clk    (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .bus          (bus),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done)
  );

  // FIFO model: one-cycle read latency, valid whenever words are queued.
  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bus.fifo_valid = (wr_ptr != rd_ptr);

  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      bus.fifo_data <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // Monitor: logs handshakes, reads and done pulses on the falling edge.
  typedef struct {
    int d; int r; int c; bit sof; bit eol; bit eof; int cyc;
  } pop_t;

  pop_t pops[$];
  int   rd_cyc[$];
  int   fd_cyc[$];
  int   cyc = 0;
  int   stab_err = 0;
  int   max_skid = 0;
  bit   hold = 1'b0;
  int   h_pix, h_row, h_col;
  pop_t p;

  always @(negedge clk) begin
    cyc++;
    if (i_rst) begin
      if (bus.fifo_rd_en) rd_cyc.push_back(cyc);
      if (o_frame_done) fd_cyc.push_back(cyc);
      if (hold && !(bus.pixel_valid && int'(bus.pixel) == h_pix &&
                    int'(bus.row) == h_row && int'(bus.col) == h_col))
        stab_err++;
      if (bus.pixel_valid && bus.pixel_ready) begin
        p.d = int'(bus.pixel); p.r = int'(bus.row); p.c = int'(bus.col);
        p.sof = bus.sof; p.eol = bus.eol; p.eof = bus.eof; p.cyc = cyc;
        pops.push_back(p);
      end
      hold  = bus.pixel_valid && !bus.pixel_ready;
      h_pix = int'(bus.pixel); h_row = int'(bus.row); h_col = int'(bus.col);
      if (int'(dut.u_skid.count) > max_skid) max_skid = int'(dut.u_skid.count);
    end else begin
      hold = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = 8'(first + i);
      wr_ptr++;
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (fd_cyc.size() > base) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_pops(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (pops.size() >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [23:0] outs;
    bus.pixel_ready = 1'b0;
    i_rst = 1'b0;
    load(1, 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({o_busy, o_frame_done, bus.pixel_valid, bus.fifo_rd_en} !== 4'b0) begin
        miscompares++;
        $display("FAIL reset_hold: busy/done/valid/rd_en=%b want 0000",
                 {o_busy, o_frame_done, bus.pixel_valid, bus.fifo_rd_en});
      end
    end
    i_rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      outs = {bus.fifo_rd_en, bus.pixel_valid, o_busy, o_frame_done, bus.sof, bus.eol,
              bus.eof, bus.pixel, bus.row, bus.col, 5'b0};
      vectors++;
      if (outs !== 24'h0) begin
        miscompares++;
        $display("FAIL idle_outputs: cycle %0d outputs=%h want 0", k, outs);
      end
    end
    vectors++;
    if (rd_cyc.size() !== 0) begin
      miscompares++;
      $display("FAIL idle_rd_en: %0d reads want 0", rd_cyc.size());
    end
    wr_ptr = rd_ptr;
  endtask

  task automatic test_full_rate();
    int b, rb, fb, n;
    bit ok;
    b = pops.size(); rb = rd_cyc.size(); fb = fd_cyc.size();
    load(0, N);
    bus.pixel_ready = 1'b1;
    pulse_start();
    wait_done(fb, 200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL full_timeout: no frame_done within budget");
    end
    tick(); tick();
    n = pops.size() - b;
    vectors++;
    if (n !== N) begin
      miscompares++;
      $display("FAIL full_count: %0d pixels want %0d", n, N);
    end
    for (int i = 0; i < n && i < N; i++) begin
      vectors++;
      if (pops[b+i].d !== i || pops[b+i].r !== i / W || pops[b+i].c !== i % W ||
          pops[b+i].sof !== (i == 0) || pops[b+i].eol !== (i % W == W - 1) ||
          pops[b+i].eof !== (i == N - 1) || pops[b+i].cyc !== pops[b].cyc + i) begin
        miscompares++;
        $display("FAIL full_pixel[%0d]: d=%0d r=%0d c=%0d sof=%b eol=%b eof=%b dc=%0d want d=%0d r=%0d c=%0d dc=%0d",
                 i, pops[b+i].d, pops[b+i].r, pops[b+i].c, pops[b+i].sof, pops[b+i].eol,
                 pops[b+i].eof, pops[b+i].cyc - pops[b].cyc, i, i / W, i % W, i);
      end
    end
    vectors++;
    if (pops[b].cyc !== rd_cyc[rb] + 2) begin
      miscompares++;
      $display("FAIL full_latency: %0d cycles want 2", pops[b].cyc - rd_cyc[rb]);
    end
    vectors++;
    if (fd_cyc.size() - fb !== 1 || fd_cyc[fb] !== pops[b+N-1].cyc + 1) begin
      miscompares++;
      $display("FAIL full_done: %0d pulses at +%0d want 1 at +1",
               fd_cyc.size() - fb, fd_cyc[fb] - pops[b+N-1].cyc);
    end
    vectors++;
    if (rd_cyc.size() - rb !== N || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_reads: %0d reads busy=%b want %0d busy=0",
               rd_cyc.size() - rb, o_busy, N);
    end
  endtask

  task automatic test_backpressure();
    int b, rb, fb, se, n;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    b = pops.size(); rb = rd_cyc.size(); fb = fd_cyc.size(); se = stab_err;
    load(100, N);
    bus.pixel_ready = 1'b1;
    pulse_start();
    for (int k = 0; k < 300 && fd_cyc.size() == fb; k++) begin
      bus.pixel_ready = pat[k % 4];
      tick();
    end
    bus.pixel_ready = 1'b1;
    tick(); tick();
    n = pops.size() - b;
    vectors++;
    if (n !== N) begin
      miscompares++;
      $display("FAIL bp_count: %0d pixels want %0d", n, N);
    end
    for (int i = 0; i < n && i < N; i++) begin
      vectors++;
      if (pops[b+i].d !== 100 + i || pops[b+i].r !== i / W || pops[b+i].c !== i % W) begin
        miscompares++;
        $display("FAIL bp_pixel[%0d]: d=%0d r=%0d c=%0d want d=%0d r=%0d c=%0d",
                 i, pops[b+i].d, pops[b+i].r, pops[b+i].c, 100 + i, i / W, i % W);
      end
    end
    vectors++;
    if (stab_err !== se) begin
      miscompares++;
      $display("FAIL bp_stable: %0d unstable stalled cycles want 0", stab_err - se);
    end
    vectors++;
    if (max_skid > 2) begin
      miscompares++;
      $display("FAIL bp_skid: peak occupancy %0d want <=2", max_skid);
    end
    vectors++;
    if (rd_cyc.size() - rb !== N || fd_cyc.size() - fb !== 1) begin
      miscompares++;
      $display("FAIL bp_reads: reads=%0d done=%0d want %0d and 1",
               rd_cyc.size() - rb, fd_cyc.size() - fb, N);
    end
  endtask

  task automatic test_starved();
    int b, fb, n;
    bit ok;
    b = pops.size(); fb = fd_cyc.size();
    load(200, 7);
    bus.pixel_ready = 1'b1;
    pulse_start();
    wait_pops(b + 7, 100, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL starve_timeout: %0d pixels before starvation want 7", pops.size() - b);
    end
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (bus.pixel_valid !== 1'b0 || bus.row !== 2'd1 || bus.col !== 2'd3) begin
      miscompares++;
      $display("FAIL starve_hold: valid=%b row=%0d col=%0d want 0 1 3",
               bus.pixel_valid, bus.row, bus.col);
    end
    load(207, 9);
    wait_done(fb, 200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL starve_done_timeout: no frame_done within budget");
    end
    n = pops.size() - b;
    vectors++;
    if (n !== N) begin
      miscompares++;
      $display("FAIL starve_count: %0d pixels want %0d", n, N);
    end
    vectors++;
    if (pops[b+7].d !== 207 || pops[b+7].r !== 1 || pops[b+7].c !== 3 ||
        pops[b+7].cyc - pops[b+6].cyc < 6) begin
      miscompares++;
      $display("FAIL starve_pixel7: d=%0d r=%0d c=%0d gap=%0d want d=207 r=1 c=3 gap>=6",
               pops[b+7].d, pops[b+7].r, pops[b+7].c, pops[b+7].cyc - pops[b+6].cyc);
    end
    for (int i = 0; i < n && i < N; i++) begin
      vectors++;
      if (pops[b+i].d !== 200 + i) begin
        miscompares++;
        $display("FAIL starve_pixel[%0d]: d=%0d want %0d", i, pops[b+i].d, 200 + i);
      end
    end
  endtask

  task automatic test_mid_reset();
    int b, fb, n;
    bit ok;
    b = pops.size();
    load(50, N);
    bus.pixel_ready = 1'b1;
    pulse_start();
    wait_pops(b + 9, 100, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midrst_timeout: %0d pixels want 9", pops.size() - b);
    end
    i_rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (o_busy !== 1'b0 || bus.pixel_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_busy: busy=%b valid=%b rd_en=%b want 0 0 0",
                 o_busy, bus.pixel_valid, bus.fifo_rd_en);
      end
    end
    wr_ptr = rd_ptr;
    i_rst = 1'b1;
    tick();
    b = pops.size(); fb = fd_cyc.size();
    load(70, N);
    pulse_start();
    wait_done(fb, 200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midrst_done_timeout: no frame_done after restart");
    end
    n = pops.size() - b;
    vectors++;
    if (n !== N || pops[b].d !== 70 || pops[b].r !== 0 || pops[b].c !== 0 || pops[b].sof !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_restart: n=%0d d=%0d r=%0d c=%0d sof=%b want n=16 d=70 r=0 c=0 sof=1",
               n, pops[b].d, pops[b].r, pops[b].c, pops[b].sof);
    end
    for (int i = 0; i < n && i < N; i++) begin
      vectors++;
      if (pops[b+i].d !== 70 + i) begin
        miscompares++;
        $display("FAIL midrst_pixel[%0d]: d=%0d want %0d", i, pops[b+i].d, 70 + i);
      end
    end
  endtask

  task automatic test_start_busy();
    int b, rb, fb, n;
    bit ok;
    b = pops.size(); rb = rd_cyc.size(); fb = fd_cyc.size();
    load(150, N);
    bus.pixel_ready = 1'b1;
    pulse_start();
    tick(); tick(); tick();
    pulse_start();
    for (int k = 0; k < 5; k++) tick();
    pulse_start();
    wait_done(fb, 200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL busy_timeout: no frame_done within budget");
    end
    for (int k = 0; k < 10; k++) tick();
    n = pops.size() - b;
    vectors++;
    if (fd_cyc.size() - fb !== 1 || rd_cyc.size() - rb !== N || n !== N || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_ignore: done=%0d reads=%0d pixels=%0d busy=%b want 1 %0d %0d 0",
               fd_cyc.size() - fb, rd_cyc.size() - rb, n, o_busy, N, N);
    end
    for (int i = 0; i < n && i < N; i++) begin
      vectors++;
      if (pops[b+i].d !== 150 + i) begin
        miscompares++;
        $display("FAIL busy_pixel[%0d]: d=%0d want %0d", i, pops[b+i].d, 150 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_starved();
    test_mid_reset();
    test_start_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
